arb_mux_reg: RTL
================

// Module: arb_mux_reg
// PURPOSE
//   Parametrised N-channel arbitrating multiplexer with a registered output stage and
//   valid/ready handshakes on every channel. It generalises the plain combinational 4:1 data mux:
//   instead of an external select, it picks one requesting channel (fixed-priority or
//   round-robin) and forwards that channel's data through one output register. It is used
//   where several requesters share one datapath, e.g. IF and MEM sharing a single memory port.
// PARAMETERS
//   WIDTH     32  data width per channel, >=1
//   CHANNELS  4   number of input channels, >=2
//   RR_MODE   1   1 = round-robin arbitration, 0 = fixed priority (channel 0 highest)
//   SEL_W     $clog2(CHANNELS)  derived localparam, width of out_sel
// PORTS
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous active-low reset
//   in_data    in   CHANNELS*WIDTH  channel i data at [i*WIDTH +: WIDTH]
//   in_valid   in   CHANNELS        channel i holds valid data
//   in_ready   out  CHANNELS        channel i transfer accepted this cycle (one-hot or zero)
//   out_data   out  WIDTH           registered data of the granted channel
//   out_sel    out  SEL_W           index of the channel that produced out_data
//   out_valid  out  1               out_data/out_sel valid
//   out_ready  in   1               downstream accepts out_data this cycle
// BEHAVIOUR
//   Reset (rst_n low, async): out_valid=0, out_data=0, out_sel=0, rr_ptr=0; in_ready=0
//     while reset is asserted. Any in-flight beat is discarded; no transfer completes
//     in the cycle in which reset deasserts unless in_valid is already asserted.
//   Transfer rule: a beat moves on a channel when valid && ready are both high at clk edge.
//   Load condition: load = !out_valid || out_ready (register empty or draining this cycle).
//   Grant (combinational, from in_valid only; in_valid never depends on in_ready):
//     RR_MODE=0: lowest-index valid channel.
//     RR_MODE=1: first valid channel searching rr_ptr, rr_ptr+1, ... wrapping modulo CHANNELS.
//     No valid channel -> no grant.
//   in_ready[g] = load && grant_valid && (g == grant); all other bits 0. One-hot or zero.
//   On clk edge with load:
//     grant_valid:  out_data <= in_data[grant], out_sel <= grant, out_valid <= 1.
//     !grant_valid: out_valid <= 0; out_data/out_sel hold their previous values.
//   Without load (out_valid && !out_ready): out_data, out_sel and out_valid hold (stall).
//   rr_ptr updates only on an accepted input beat: rr_ptr <= (grant==CHANNELS-1) ? 0 : grant+1.
//     It holds during stalls and idle cycles. It is unused when RR_MODE=0.
//   Latency: 1 cycle from input accept to out_valid. Throughput: 1 beat/cycle when out_ready=1.
//   Simultaneous drain+fill: when out_valid && out_ready and a channel is granted, the new
//     beat replaces the old beat in the same edge (no bubble).
//   Starvation: with RR_MODE=1, a continuously valid channel is granted within CHANNELS beats.
//     With RR_MODE=0, starvation of low-priority channels is permitted by design.
//   Non-power-of-2 CHANNELS: rr_ptr and grant never exceed CHANNELS-1.
//   A requester may drop in_valid before it is granted; no state is kept for it.
// TESTING
//   1 Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0
//     immediately (async), in_ready=0; after release, the first grant goes to channel 0.
//   2 Single channel: in_valid=4'b0100, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100;
//     next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel=2.
//   3 Round-robin (RR_MODE=1): in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0,1
//     at one beat per cycle; with RR_MODE=0 the same stimulus gives out_sel 0,0,0,...
//   4 Back-pressure: out_valid=1 with out_sel=1, out_ready=0 for 3 cycles, in_valid=4'b1011 ->
//     in_ready=0, out_data/out_sel stable, rr_ptr unchanged; on out_ready=1 -> channel 3 granted
//     (rr_ptr=2, channel 2 not valid).
//   5 Drain+fill: out_valid=1, out_ready=1, in_valid=4'b0001 -> in_ready=4'b0001, out_valid stays
//     1, out_data updates next edge with no idle cycle; with in_valid=0 instead -> out_valid=0.
//   6 CHANNELS=3, WIDTH=8, RR_MODE=1: in_valid=3'b111 held -> out_sel 0,1,2,0; rr_ptr never 3;
//     random valid/ready soak with a scoreboard: every accepted beat appears exactly once, in order.

Source files
------------

// File: rtl/arb_mux_reg.sv
// N-channel arbitrating multiplexer: picks one valid requester (round-robin or fixed
// priority) and forwards its data through a single registered output stage.
module arb_mux_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int RR_MODE  = 1,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [SEL_W-1:0]             out_sel,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic [WIDTH-1:0]               lane [CHANNELS];
    logic [SEL_W-1:0]               rr_ptr_reg;
    logic [WIDTH-1:0]               out_data_reg;
    logic [SEL_W-1:0]               out_sel_reg;
    logic                           out_valid_reg;

    logic                           load;
    logic                           grant_valid;
    logic [SEL_W-1:0]               grant;
    logic [SEL_W-1:0]               base;
    logic [CHANNELS-1:0]            rot_valid;
    logic [CHANNELS-1:0]            take;
    logic [CHANNELS:0][SEL_W-1:0]   off_chain;
    logic [SEL_W:0]                 sum;

    assign load        = !out_valid_reg || out_ready;
    assign grant_valid = |in_valid;

    // Rotate the request vector so the search always starts at bit 0, then map the
    // winning offset back to a channel index modulo CHANNELS.
    assign base      = (RR_MODE != 0) ? rr_ptr_reg : '0;
    assign rot_valid = CHANNELS'({in_valid, in_valid} >> base);
    assign off_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign lane[gi] = in_data[gi*WIDTH +: WIDTH];

            if (gi == 0) begin : g_first
                assign take[gi] = rot_valid[0];
            end else begin : g_rest
                assign take[gi] = rot_valid[gi] & ~(|rot_valid[gi-1:0]);
            end

            assign off_chain[gi+1] = off_chain[gi] | (take[gi] ? SEL_W'(gi) : '0);
            assign in_ready[gi]    = rst_n & load & grant_valid & (grant == SEL_W'(gi));
        end
    endgenerate

    assign sum   = {1'b0, base} + {1'b0, off_chain[CHANNELS]};
    assign grant = (sum >= (SEL_W+1)'(CHANNELS)) ? SEL_W'(sum - (SEL_W+1)'(CHANNELS))
                                                 : sum[SEL_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= lane[grant];
                out_sel_reg   <= grant;
                rr_ptr_reg    <= (grant == SEL_W'(CHANNELS-1)) ? '0 : grant + SEL_W'(1);
            end else begin
                // Data and select hold so a bubble does not disturb the last beat.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = out_valid_reg;

endmodule
